// File: rtl/signed_vector_addsub_pipe_if.sv
// Valid/ready bus for the signed vector add/sub pipeline: one request side and one result side.
// The slave modport is the pipeline's view; the master modport is the view of whoever drives it.
interface signed_vector_addsub_pipe_if #(
  parameter int unsigned COMP_WIDTH = 19,
  parameter int unsigned NUM_COMP   = 3
);
  logic                           in_valid;
  logic                           in_ready;
  logic                           in_mode;
  logic [NUM_COMP*COMP_WIDTH-1:0] in_vector_1;
  logic [NUM_COMP*COMP_WIDTH-1:0] in_vector_2;
  logic                           out_valid;
  logic                           out_ready;
  logic [NUM_COMP*COMP_WIDTH-1:0] out_vector;
  logic [NUM_COMP-1:0]            out_ovf;

  modport master (
    output in_valid, in_mode, in_vector_1, in_vector_2, out_ready,
    input  in_ready, out_valid, out_vector, out_ovf
  );

  modport slave (
    input  in_valid, in_mode, in_vector_1, in_vector_2, out_ready,
    output in_ready, out_valid, out_vector, out_ovf
  );
endinterface

// File: rtl/signed_vector_addsub_pipe.sv
// Two-stage pipelined per-component signed add/subtract on packed vectors.
// Optional saturation and per-component overflow flags; full valid/ready backpressure.
module signed_vector_addsub_pipe #(
  parameter int unsigned COMP_WIDTH = 19,
  parameter int unsigned NUM_COMP   = 3,
  parameter int unsigned SATURATE   = 1
) (
  input logic                           clk,
  input logic                           rst,
  signed_vector_addsub_pipe_if.slave    bus
);
  localparam int unsigned VW = NUM_COMP * COMP_WIDTH;
  localparam int unsigned RW = COMP_WIDTH + 1;

  logic                   s1_valid;
  logic                   s1_en;
  logic                   s2_en;
  logic [NUM_COMP*RW-1:0] s1_sum;
  logic [NUM_COMP*RW-1:0] sum_next;
  logic [RW-1:0]          a_ext;
  logic [RW-1:0]          b_ext;
  logic [RW-1:0]          r;
  logic [VW-1:0]          res_next;
  logic [NUM_COMP-1:0]    ovf_next;
  logic                   out_valid_q;
  logic [VW-1:0]          out_vector_q;
  logic [NUM_COMP-1:0]    out_ovf_q;

  assign s2_en          = !out_valid_q || bus.out_ready;
  assign s1_en          = !s1_valid || s2_en;
  assign bus.in_ready   = s1_en;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_vector = out_vector_q;
  assign bus.out_ovf    = out_ovf_q;

  // One extra bit keeps a-b exact, including negation of the most negative b.
  always_comb begin
    sum_next = '0;
    a_ext    = '0;
    b_ext    = '0;
    for (int unsigned i = 0; i < NUM_COMP; i++) begin
      a_ext = {bus.in_vector_1[i*COMP_WIDTH + COMP_WIDTH - 1],
               bus.in_vector_1[i*COMP_WIDTH +: COMP_WIDTH]};
      b_ext = {bus.in_vector_2[i*COMP_WIDTH + COMP_WIDTH - 1],
               bus.in_vector_2[i*COMP_WIDTH +: COMP_WIDTH]};
      sum_next[i*RW +: RW] = bus.in_mode ? (a_ext - b_ext) : (a_ext + b_ext);
    end
  end

  always_comb begin
    res_next = '0;
    ovf_next = '0;
    r        = '0;
    for (int unsigned i = 0; i < NUM_COMP; i++) begin
      r           = s1_sum[i*RW +: RW];
      ovf_next[i] = r[RW-1] ^ r[RW-2];
      if ((SATURATE != 0) && ovf_next[i])
        res_next[i*COMP_WIDTH +: COMP_WIDTH] = r[RW-1] ? {1'b1, {(COMP_WIDTH-1){1'b0}}}
                                                       : {1'b0, {(COMP_WIDTH-1){1'b1}}};
      else
        res_next[i*COMP_WIDTH +: COMP_WIDTH] = r[COMP_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_sum       <= '0;
      out_valid_q  <= 1'b0;
      out_vector_q <= '0;
      out_ovf_q    <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) s1_sum <= sum_next;
      end
      if (s2_en) begin
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          out_vector_q <= res_next;
          out_ovf_q    <= ovf_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_signed_vector_addsub_pipe.sv
// Bench for signed_vector_addsub_pipe: saturating and wrapping 19x3 instances share random stimulus
// and are checked against an integer-arithmetic model; 8x4 instances get directed overflow cases.
module tb_signed_vector_addsub_pipe;
  localparam int W  = 19;
  localparam int N  = 3;
  localparam int VW = W * N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  signed_vector_addsub_pipe_if #(.COMP_WIDTH(19), .NUM_COMP(3)) bs ();
  signed_vector_addsub_pipe_if #(.COMP_WIDTH(19), .NUM_COMP(3)) bw ();
  signed_vector_addsub_pipe_if #(.COMP_WIDTH(8),  .NUM_COMP(4)) s8 ();
  signed_vector_addsub_pipe_if #(.COMP_WIDTH(8),  .NUM_COMP(4)) w8 ();

  signed_vector_addsub_pipe #(.COMP_WIDTH(19), .NUM_COMP(3), .SATURATE(1)) dut_sat   (.clk(clk), .rst(rst), .bus(bs));
  signed_vector_addsub_pipe #(.COMP_WIDTH(19), .NUM_COMP(3), .SATURATE(0)) dut_wrap  (.clk(clk), .rst(rst), .bus(bw));
  signed_vector_addsub_pipe #(.COMP_WIDTH(8),  .NUM_COMP(4), .SATURATE(1)) dut_sat8  (.clk(clk), .rst(rst), .bus(s8));
  signed_vector_addsub_pipe #(.COMP_WIDTH(8),  .NUM_COMP(4), .SATURATE(0)) dut_wrap8 (.clk(clk), .rst(rst), .bus(w8));

  typedef struct {
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic          mode;
  } txn_t;

  txn_t q_sat[$];
  txn_t q_wrap[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Plain integer arithmetic per component, then clamp or keep the low bits.
  function automatic void model(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic mode,
                                input bit sat, output logic [VW-1:0] v, output logic [N-1:0] o);
    int maxv;
    int minv;
    maxv = (1 << (W-1)) - 1;
    minv = -(1 << (W-1));
    v = '0;
    o = '0;
    for (int i = 0; i < N; i++) begin
      logic [W-1:0] ac;
      logic [W-1:0] bc;
      int r;
      ac = a[i*W +: W];
      bc = b[i*W +: W];
      r  = mode ? (int'($signed(ac)) - int'($signed(bc))) : (int'($signed(ac)) + int'($signed(bc)));
      o[i] = (r > maxv) || (r < minv);
      if (sat && r > maxv) r = maxv;
      else if (sat && r < minv) r = minv;
      v[i*W +: W] = r[W-1:0];
    end
  endfunction

  function automatic logic [VW-1:0] rvec();
    logic [VW-1:0] v;
    logic [W-1:0]  c;
    v = '0;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 5))
        0:       c = 19'h3FFFF;
        1:       c = 19'h40000;
        2:       c = '0;
        3:       c = '1;
        4:       c = 19'h00001;
        default: c = W'($urandom);
      endcase
      v[i*W +: W] = c;
    end
    return v;
  endfunction

  task automatic drive(input logic v, input logic m, input logic [VW-1:0] a, input logic [VW-1:0] b,
                       input logic ordy);
    bs.in_valid = v; bs.in_mode = m; bs.in_vector_1 = a; bs.in_vector_2 = b; bs.out_ready = ordy;
    bw.in_valid = v; bw.in_mode = m; bw.in_vector_1 = a; bw.in_vector_2 = b; bw.out_ready = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard/monitor: handshakes are judged on the negative edge, before the rising edge commits them.
  logic          hold_s, hold_w;
  logic [VW-1:0] held_vs, held_vw, ev;
  logic [N-1:0]  held_os, held_ow, eo;
  txn_t          t;

  always @(negedge clk) begin
    if (rst) begin
      q_sat.delete();
      q_wrap.delete();
      hold_s = 1'b0;
      hold_w = 1'b0;
    end else begin
      if (hold_s) begin
        check("hold_valid_sat", bs.out_valid, 1);
        check("hold_vec_sat", bs.out_vector, held_vs);
        check("hold_ovf_sat", bs.out_ovf, held_os);
      end
      if (hold_w) begin
        check("hold_valid_wrap", bw.out_valid, 1);
        check("hold_vec_wrap", bw.out_vector, held_vw);
        check("hold_ovf_wrap", bw.out_ovf, held_ow);
      end
      check("in_ready_sat", bs.in_ready, !(q_sat.size() == 2 && !bs.out_ready));
      check("in_ready_wrap", bw.in_ready, !(q_wrap.size() == 2 && !bw.out_ready));

      if (bs.out_valid && bs.out_ready) begin
        if (q_sat.size() == 0) begin
          tests++; fails++;
          $display("FAIL stale_sat: got unexpected result %h expected no result", bs.out_vector);
        end else begin
          t = q_sat.pop_front();
          model(t.a, t.b, t.mode, 1'b1, ev, eo);
          check("vec_sat", bs.out_vector, ev);
          check("ovf_sat", bs.out_ovf, eo);
        end
      end
      if (bw.out_valid && bw.out_ready) begin
        if (q_wrap.size() == 0) begin
          tests++; fails++;
          $display("FAIL stale_wrap: got unexpected result %h expected no result", bw.out_vector);
        end else begin
          t = q_wrap.pop_front();
          model(t.a, t.b, t.mode, 1'b0, ev, eo);
          check("vec_wrap", bw.out_vector, ev);
          check("ovf_wrap", bw.out_ovf, eo);
        end
      end

      hold_s = bs.out_valid && !bs.out_ready; held_vs = bs.out_vector; held_os = bs.out_ovf;
      hold_w = bw.out_valid && !bw.out_ready; held_vw = bw.out_vector; held_ow = bw.out_ovf;

      if (bs.in_valid && bs.in_ready) begin
        t.a = bs.in_vector_1; t.b = bs.in_vector_2; t.mode = bs.in_mode;
        q_sat.push_back(t);
      end
      if (bw.in_valid && bw.in_ready) begin
        t.a = bw.in_vector_1; t.b = bw.in_vector_2; t.mode = bw.in_mode;
        q_wrap.push_back(t);
      end
    end
  end

  // One transaction with out_ready high; result must appear exactly two cycles after acceptance.
  task automatic dir(input string name, input logic [VW-1:0] a, input logic [VW-1:0] b, input logic m,
                     input logic [VW-1:0] es, input logic [N-1:0] os,
                     input logic [VW-1:0] ew, input logic [N-1:0] ow);
    int k;
    drive(1'b1, m, a, b, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bs.out_valid && k < 8);
    check({name, "_latency"}, k, 2);
    check({name, "_vec_sat"}, bs.out_vector, es);
    check({name, "_ovf_sat"}, bs.out_ovf, os);
    check({name, "_vec_wrap"}, bw.out_vector, ew);
    check({name, "_ovf_wrap"}, bw.out_ovf, ow);
    next_cycle();
  endtask

  task automatic dir8(input string name, input logic [31:0] a, input logic [31:0] b, input logic m,
                      input logic [31:0] es, input logic [31:0] ew, input logic [3:0] eo);
    int k;
    s8.in_valid = 1'b1; s8.in_mode = m; s8.in_vector_1 = a; s8.in_vector_2 = b;
    w8.in_valid = 1'b1; w8.in_mode = m; w8.in_vector_1 = a; w8.in_vector_2 = b;
    next_cycle();
    s8.in_valid = 1'b0;
    w8.in_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!s8.out_valid && k < 8);
    check({name, "_latency"}, k, 2);
    check({name, "_vec_sat"}, s8.out_vector, es);
    check({name, "_ovf_sat"}, s8.out_ovf, eo);
    check({name, "_vec_wrap"}, w8.out_vector, ew);
    check({name, "_ovf_wrap"}, w8.out_ovf, eo);
    next_cycle();
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    logic [5:0] pat;
    int sent;
    int cyc;

    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    s8.in_valid = 1'b0; s8.in_mode = 1'b0; s8.in_vector_1 = '0; s8.in_vector_2 = '0; s8.out_ready = 1'b1;
    w8.in_valid = 1'b0; w8.in_mode = 1'b0; w8.in_vector_1 = '0; w8.in_vector_2 = '0; w8.out_ready = 1'b1;
    repeat (3) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", bs.out_valid, 0);
    check("reset_out_vector", bs.out_vector, 0);
    check("reset_out_ovf", bs.out_ovf, 0);
    check("reset_in_ready", bs.in_ready, 1);
    next_cycle();

    dir("neg_one", {VW{1'b1}}, '0, 1'b1, 57'h1FFFFFFFFFFFFFF, 3'b000, 57'h1FFFFFFFFFFFFFF, 3'b000);
    dir("plus_one", '0, {VW{1'b1}}, 1'b1, {19'h00001, 19'h00001, 19'h00001}, 3'b000,
        {19'h00001, 19'h00001, 19'h00001}, 3'b000);
    dir("ovf_add", {19'h0, 19'h0, 19'h3FFFF}, {19'h0, 19'h0, 19'h00001}, 1'b0,
        {19'h0, 19'h0, 19'h3FFFF}, 3'b001, {19'h0, 19'h0, 19'h40000}, 3'b001);
    dir("ovf_sub", {19'h40000, 19'h00000, 19'h0}, {19'h00001, 19'h40000, 19'h0}, 1'b1,
        {19'h40000, 19'h3FFFF, 19'h0}, 3'b110, {19'h3FFFF, 19'h40000, 19'h0}, 3'b110);
    dir("mixed", {19'h00005, 19'h7FFFD, 19'h00010}, {19'h00003, 19'h00004, 19'h00020}, 1'b0,
        {19'h00008, 19'h00001, 19'h00030}, 3'b000, {19'h00008, 19'h00001, 19'h00030}, 3'b000);

    dir8("w8_ovf", 32'h7F7F7F7F, 32'hFFFFFFFF, 1'b1, 32'h7F7F7F7F, 32'h80808080, 4'hF);
    dir8("w8_plain", 32'h10101010, 32'h05050505, 1'b0, 32'h15151515, 32'h15151515, 4'h0);

    // Backpressure: six transactions under a 1,0,0,1,0,1 out_ready pattern; operands churn while stalled.
    pat  = 6'b101001;
    sent = 0;
    cyc  = 0;
    while ((sent < 6 || q_sat.size() != 0) && cyc < 200) begin
      drive(sent < 6, 1'($urandom_range(0, 1)), rvec(), rvec(), pat[cyc % 6]);
      @(negedge clk);
      if (bs.in_valid && bs.in_ready) sent++;
      next_cycle();
      cyc++;
    end
    check("bp_all_sent", sent, 6);
    check("bp_drained", q_sat.size(), 0);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    repeat (3) next_cycle();

    // Full throughput: 20 back-to-back with out_ready high; out_valid high exactly in cycles 2..21.
    for (int i = 0; i < 24; i++) begin
      drive(i < 20, (i % 2) == 1, rvec(), rvec(), 1'b1);
      @(negedge clk);
      check("tput_valid", bs.out_valid, (i >= 2 && i <= 21));
      next_cycle();
    end

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rvec(), rvec(), $urandom_range(0, 2) != 0);
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    repeat (4) next_cycle();
    check("rand_drained_sat", q_sat.size(), 0);
    check("rand_drained_wrap", q_wrap.size(), 0);

    // Mid-stream reset with both stages full: everything in flight is discarded.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, rvec(), rvec(), 1'b0);
      next_cycle();
    end
    rst = 1'b1;
    repeat (3) next_cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    check("midrst_out_valid", bs.out_valid, 0);
    check("midrst_out_vector", bs.out_vector, 0);
    check("midrst_out_ovf", bs.out_ovf, 0);
    check("midrst_in_ready", bs.in_ready, 1);
    check("midrst_wrap_valid", bw.out_valid, 0);
    next_cycle();
    repeat (5) next_cycle();

    dir("post_reset", {19'h00002, 19'h00002, 19'h00002}, {19'h00003, 19'h00003, 19'h00003}, 1'b1,
        {19'h7FFFF, 19'h7FFFF, 19'h7FFFF}, 3'b000, {19'h7FFFF, 19'h7FFFF, 19'h7FFFF}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/signed_vector_addsub_pipe.md
Name: signed_vector_addsub_pipe

Overview:
Parametrised, pipelined successor to the combinational signed vector subtractor in the ray-tracing datapath. Performs per-component signed add or subtract on packed vectors of NUM_COMP components, COMP_WIDTH bits each, selectable per transaction. Optional saturation and per-component overflow flags. Valid/ready handshakes on both sides so it sits between ray-generation and intersection stages with full backpressure.

Parameters:
COMP_WIDTH, 19, bits per signed two's-complement component
NUM_COMP, 3, components per vector (3 = x,y,z)
SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  input transaction valid
in_ready  output  1  block accepts input this cycle
in_mode  input  1  0 = a+b, 1 = a-b
in_vector_1  input  NUM_COMP*COMP_WIDTH  operand a; component i at [i*COMP_WIDTH +: COMP_WIDTH], component 0 in LSBs
in_vector_2  input  NUM_COMP*COMP_WIDTH  operand b, same packing
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_vector  output  NUM_COMP*COMP_WIDTH  result, same packing
out_ovf  output  NUM_COMP  bit i set if component i overflowed (set regardless of SATURATE)

Behaviour:
- Single clock domain; reset synchronous, active-high, sampled on rising clk edge.
- Reset: out_valid=0, out_vector=0, out_ovf=0, both stage valid bits=0; in_ready=1 in the first cycle after reset deasserts. Reset mid-operation discards all in-flight transactions; no partial results emitted.
- Transfer occurs on a cycle where valid && ready are both 1 (either side).
- Two register stages, latency exactly 2 cycles from input accept to out_valid with out_ready held high; throughput 1 per cycle.
- Stage 1 (S1): on accept, compute per component r = sext(a) + (mode ? -sext(b) : sext(b)) at COMP_WIDTH+1 bits; register r, s1_valid.
- Stage 2 (S2): ovf_i = (r[MSB] != r[MSB-1]). SATURATE=1: ovf and r negative -> most negative value (1 followed by zeros); ovf and r positive -> most positive value (0 followed by ones); else low COMP_WIDTH bits. SATURATE=0: low COMP_WIDTH bits always. Register out_vector, out_ovf, out_valid.
- Negation of the most negative b is exact (done at COMP_WIDTH+1 bits); 0 - (-2^(W-1)) flags overflow.
- Stall rules: s2_en = !out_valid || out_ready; s1_en = !s1_valid || s2_en; in_ready = s1_en (combinational from out_ready and valid state).
- While out_valid=1 and out_ready=0: out_vector, out_ovf held stable; S1 holds its data; once S1 is full, in_ready=0.
- Simultaneous out handshake and in accept on a full pipe: S2 loads S1, S1 loads new input, no bubble, no loss.
- out_valid drops to 0 after a handshake only if S1 is empty that cycle.
- in_mode and operands sampled only on accepted cycles; ignored otherwise.
- No reordering; results leave in acceptance order.

Test Plan:
- Reset/idle: assert rst 3 cycles mid-stream with S1,S2 full -> next cycle out_valid=0, out_vector=0, out_ovf=0, in_ready=1; no stale results afterwards.
- Basic sub, defaults: a = all 57 ones (each comp -1), b = 0, mode=1 -> 2 cycles later out_vector = 57'h1FFFFFFFFFFFFFF, out_ovf=3'b000; a=0, b=all ones, mode=1 -> each comp +1 (19'h00001), ovf=000.
- Overflow, SATURATE=1: comp0 a=19'h3FFFF, b=19'h00001 add -> 19'h3FFFF, ovf[0]=1; comp1 a=0, b=19'h40000 sub -> 19'h3FFFF, ovf[1]=1; comp2 a=19'h40000, b=19'h00001 sub -> 19'h40000, ovf[2]=1. SATURATE=0 same stimulus -> 19'h40000, 19'h40000, 19'h3FFFF, ovf=3'b111.
- Backpressure: stream 6 random vectors with in_valid=1, out_ready toggling 1,0,0,1,0,1... -> outputs held stable while stalled, in_ready=0 once both stages full, all 6 results match scoreboard (golden per-component model) in order, no duplicates.
- Full throughput: 20 back-to-back transactions alternating mode with out_ready=1 -> out_valid high continuously from cycle 2 to cycle 21, each result = golden a±b.
- Parameter sweep: COMP_WIDTH=8, NUM_COMP=4 -> a=8'h7F,b=8'hFF sub (127-(-1)) -> 8'h7F with ovf=1 (SATURATE=1), 8'h80 with ovf=1 (SATURATE=0).
